sid_filter_mc: RTL and testbench

SID_FILTER_MC -- requirements
Module: sid_filter_mc

---
 rtl/sid_filter_mc_if.sv | 35 +++
 rtl/sid_filter_mc.sv | 204 ++++++++++++++++++++
 tb/tb_sid_filter_mc.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/sid_filter_mc_if.sv
// sid_filter_mc_if -- bundle of the request/response signals of sid_filter_mc.
//   start            : one-cycle request to update all channels
//   vi, vd           : per-channel filter input and direct-path sums (signed)
//   w0, q_inv        : per-channel cutoff (signed) and 1/Q (unsigned) coefficients
//   mode, vol        : per-channel LP/BP/HP output select and master volume
//   busy, done       : sequence running / one-cycle completion pulse
//   audio, sat       : per-channel volume-scaled output and sticky clip flag
// master: the block issuing requests; slave: the filter.
interface sid_filter_mc_if #(
   parameter int CHANNELS = 2,
   parameter int DATA_W   = 24,
   parameter int COEF_W   = 16
);
   logic                         start;
   logic [CHANNELS*DATA_W-1:0]   vi;
   logic [CHANNELS*DATA_W-1:0]   vd;
   logic [CHANNELS*COEF_W-1:0]   w0;
   logic [CHANNELS*COEF_W-1:0]   q_inv;
   logic [CHANNELS*3-1:0]        mode;
   logic [CHANNELS*4-1:0]        vol;
   logic                         busy;
   logic                         done;
   logic [CHANNELS*DATA_W-1:0]   audio;
   logic [CHANNELS-1:0]          sat;

   modport master (
      output start, vi, vd, w0, q_inv, mode, vol,
      input  busy, done, audio, sat
   );

   modport slave (
      input  start, vi, vd, w0, q_inv, mode, vol,
      output busy, done, audio, sat
   );
endinterface

// File: rtl/sid_filter_mc.sv
// sid_filter_mc -- multi-channel SID-style state-variable filter sharing one
// multiplier. Each start runs BP, LP, HP and OUT for channel 0, then channel 1,
// and so on; done pulses one cycle after the last OUT.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : sid_filter_mc_if slave modport (start/busy/done, per-channel
//          inputs, audio and sat outputs)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; busy low
// BP    | vbp update from old vhp; old vbp saved for LP
// LP    | vlp update from the saved (old) vbp
// HP    | vhp update from new vbp and new vlp
// OUT   | mix, clip and volume-scale into audio; next channel or IDLE
module sid_filter_mc #(
   parameter int CHANNELS = 2,
   parameter int DATA_W   = 24,
   parameter int COEF_W   = 16,
   parameter int W0_FRAC  = 17
) (
   input  logic            clk,
   input  logic            rst,
   sid_filter_mc_if.slave  bus
);

   localparam int SH   = W0_FRAC - (DATA_W - COEF_W);
   // One extra operand bit lets the unsigned q_inv and volume share the
   // signed multiplier without being misread as negative.
   localparam int MW   = COEF_W + 1;
   localparam int PW   = 2 * MW;
   localparam int WW   = ((PW > DATA_W) ? PW : DATA_W) + 4;
   localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_BP   = 3'd1;
   localparam logic [2:0] S_LP   = 3'd2;
   localparam logic [2:0] S_HP   = 3'd3;
   localparam logic [2:0] S_OUT  = 3'd4;

   localparam logic signed [WW-1:0] MAX_W  = {{(WW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [WW-1:0] MIN_W  = {{(WW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
   localparam logic signed [WW-1:0] ZERO_W = '0;

   logic [2:0]              state;
   logic [CH_W-1:0]         ch;
   logic                    done_r;
   logic [CHANNELS-1:0]     sat_r;
   logic signed [DATA_W-1:0] vlp [CHANNELS];
   logic signed [DATA_W-1:0] vbp [CHANNELS];
   logic signed [DATA_W-1:0] vhp [CHANNELS];
   logic signed [DATA_W-1:0] audio_r [CHANNELS];
   logic signed [DATA_W-1:0] vbp_old;

   logic signed [DATA_W-1:0] vi_a [CHANNELS];
   logic signed [DATA_W-1:0] vd_a [CHANNELS];
   logic signed [COEF_W-1:0] w0_a [CHANNELS];
   logic [COEF_W-1:0]        q_a  [CHANNELS];
   logic [2:0]               mode_a [CHANNELS];
   logic [3:0]               vol_a  [CHANNELS];

   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         vi_a[i]   = bus.vi[i*DATA_W +: DATA_W];
         vd_a[i]   = bus.vd[i*DATA_W +: DATA_W];
         w0_a[i]   = bus.w0[i*COEF_W +: COEF_W];
         q_a[i]    = bus.q_inv[i*COEF_W +: COEF_W];
         mode_a[i] = bus.mode[i*3 +: 3];
         vol_a[i]  = bus.vol[i*4 +: 4];
      end
   end

   function automatic logic signed [MW-1:0] hi_op(input logic signed [DATA_W-1:0] x);
      logic signed [COEF_W-1:0] h;
      h = x[DATA_W-1 -: COEF_W];
      return {h[COEF_W-1], h};
   endfunction

   function automatic logic signed [DATA_W-1:0] clamp(input logic signed [WW-1:0] x);
      if (x > MAX_W)      return MAX_W[DATA_W-1:0];
      else if (x < MIN_W) return MIN_W[DATA_W-1:0];
      else                return x[DATA_W-1:0];
   endfunction

   logic signed [WW-1:0]     amix_w, t_lp, t_bp, t_hp, upd_w;
   logic signed [DATA_W-1:0] amix_c, upd_c;
   logic                     amix_clip, upd_clip;
   logic signed [MW-1:0]     op_a, op_b;
   logic signed [PW-1:0]     prod;

   // Evaluated in order: mix first (needs no product), then operands,
   // product, and finally the state update that consumes the product.
   always_comb begin
      t_lp = ZERO_W;
      t_bp = ZERO_W;
      t_hp = ZERO_W;
      if (mode_a[ch][0]) t_lp = WW'(vlp[ch]);
      if (mode_a[ch][1]) t_bp = WW'(vbp[ch]);
      if (mode_a[ch][2]) t_hp = WW'(vhp[ch]);
      amix_w    = WW'(vd_a[ch]) + t_lp + t_bp + t_hp;
      amix_c    = clamp(amix_w);
      amix_clip = (amix_w > MAX_W) || (amix_w < MIN_W);

      op_a = '0;
      op_b = '0;
      case (state)
         S_BP: begin
            op_a = {w0_a[ch][COEF_W-1], w0_a[ch]};
            op_b = hi_op(vhp[ch]);
         end
         S_LP: begin
            op_a = {w0_a[ch][COEF_W-1], w0_a[ch]};
            op_b = hi_op(vbp_old);
         end
         S_HP: begin
            op_a = {1'b0, q_a[ch]};
            op_b = hi_op(vbp[ch]);
         end
         S_OUT: begin
            op_a = MW'({vol_a[ch], 4'b0000});
            op_b = hi_op(amix_c);
         end
         default: ;
      endcase
      prod = op_a * op_b;

      upd_w = ZERO_W;
      case (state)
         S_BP:    upd_w = WW'(vbp[ch]) - WW'(prod >>> SH);
         S_LP:    upd_w = WW'(vlp[ch]) - WW'(prod >>> SH);
         S_HP:    upd_w = WW'(prod) - WW'(vlp[ch]) - WW'(vi_a[ch]);
         default: upd_w = ZERO_W;
      endcase
      upd_c    = clamp(upd_w);
      upd_clip = (upd_w > MAX_W) || (upd_w < MIN_W);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         ch      <= '0;
         done_r  <= 1'b0;
         sat_r   <= '0;
         vbp_old <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            vlp[i]     <= '0;
            vbp[i]     <= '0;
            vhp[i]     <= '0;
            audio_r[i] <= '0;
         end
      end else begin
         done_r <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  state <= S_BP;
                  ch    <= '0;
                  sat_r <= '0;
               end
            end
            S_BP: begin
               vbp_old <= vbp[ch];
               vbp[ch] <= upd_c;
               if (upd_clip) sat_r[ch] <= 1'b1;
               state <= S_LP;
            end
            S_LP: begin
               vlp[ch] <= upd_c;
               if (upd_clip) sat_r[ch] <= 1'b1;
               state <= S_HP;
            end
            S_HP: begin
               vhp[ch] <= upd_c;
               if (upd_clip) sat_r[ch] <= 1'b1;
               state <= S_OUT;
            end
            S_OUT: begin
               audio_r[ch] <= prod[DATA_W-1:0];
               if (amix_clip) sat_r[ch] <= 1'b1;
               if (ch == CH_W'(CHANNELS-1)) begin
                  state  <= S_IDLE;
                  done_r <= 1'b1;
               end else begin
                  ch    <= ch + 1'b1;
                  state <= S_BP;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      bus.audio = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         bus.audio[i*DATA_W +: DATA_W] = audio_r[i];
      end
   end

   assign bus.busy = (state != S_IDLE);
   assign bus.done = done_r;
   assign bus.sat  = sat_r;

endmodule

// File: tb/tb_sid_filter_mc.sv
module tb_sid_filter_mc;
   localparam int CH = 2;
   localparam int DW = 24;
   localparam int CW = 16;
   localparam longint MAXV = (64'sd1 <<< 23) - 1;
   localparam longint MINV = -(64'sd1 <<< 23);

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sid_filter_mc_if #(.CHANNELS(CH), .DATA_W(DW), .COEF_W(CW)) bus ();

   sid_filter_mc #(.CHANNELS(CH), .DATA_W(DW), .COEF_W(CW), .W0_FRAC(17)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic signed [23:0] vi0, vi1, vd0, vd1;
      logic [15:0]        q0, q1;
      logic [2:0]         m0, m1;
      logic [3:0]         v0, v1;
      logic signed [23:0] a0, a1;
      logic [1:0]         sat;
   } vec_t;

   vec_t vec [4];

   longint mlp [CH], mbp [CH], mhp [CH];
   longint exp_a [CH];
   bit     exp_s [CH];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input logic signed [23:0] vi0, vi1, vd0, vd1,
                        input logic signed [15:0] w00, w01,
                        input logic [15:0] q0, q1,
                        input logic [2:0] m0, m1, input logic [3:0] v0, v1);
      bus.vi    = {vi1, vi0};
      bus.vd    = {vd1, vd0};
      bus.w0    = {w01, w00};
      bus.q_inv = {q1, q0};
      bus.mode  = {m1, m0};
      bus.vol   = {v1, v0};
   endtask

   // start, then wait (bounded) for done; on return we are in the done cycle
   task automatic run_seq();
      bit seen;
      seen = 0;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (bus.done === 1'b1) begin
            seen = 1;
            break;
         end
         tick();
      end
      if (!seen) begin
         n_checks++;
         n_errors++;
         $display("FAIL done_timeout: got no done, expected done within 40 cycles");
      end
   endtask

   function automatic longint sat24(input longint x, inout bit c);
      if (x > MAXV) begin c = 1; return MAXV; end
      if (x < MINV) begin c = 1; return MINV; end
      return x;
   endfunction

   function automatic longint hi(input longint x);
      return x >>> 8;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < CH; c++) begin
         mlp[c] = 0; mbp[c] = 0; mhp[c] = 0;
      end
   endtask

   task automatic model_seq();
      for (int c = 0; c < CH; c++) begin
         longint vi, vd, w0, q, old_bp, amix, vol;
         logic [2:0] m;
         bit s;
         vi  = longint'($signed(bus.vi[c*DW +: DW]));
         vd  = longint'($signed(bus.vd[c*DW +: DW]));
         w0  = longint'($signed(bus.w0[c*CW +: CW]));
         q   = longint'({48'd0, bus.q_inv[c*CW +: CW]});
         m   = bus.mode[c*3 +: 3];
         vol = longint'({60'd0, bus.vol[c*4 +: 4]});
         s = 0;
         old_bp = mbp[c];
         mbp[c] = sat24(mbp[c] - ((w0 * hi(mhp[c])) >>> 9), s);
         mlp[c] = sat24(mlp[c] - ((w0 * hi(old_bp)) >>> 9), s);
         mhp[c] = sat24(q * hi(mbp[c]) - mlp[c] - vi, s);
         amix = vd + (m[0] ? mlp[c] : 0) + (m[1] ? mbp[c] : 0) + (m[2] ? mhp[c] : 0);
         amix = sat24(amix, s);
         exp_a[c] = vol * 16 * hi(amix);
         exp_s[c] = s;
      end
   endtask

   initial begin
      // w0 = 0 throughout the table, so vlp/vbp stay 0 and vhp = -vi
      vec[0] = '{24'sd1000, 24'sd0, 24'sd0, 24'sd4096, 16'd0, 16'd0, 3'b100, 3'b000, 4'd15, 4'd1,
                 -24'sd960, 24'sd256, 2'b00};
      vec[1] = '{-24'sd8388608, 24'sd0, 24'sd0, -24'sd256, 16'd0, 16'd0, 3'b100, 3'b001, 4'd0, 4'd2,
                 24'sd0, -24'sd32, 2'b01};
      vec[2] = '{-24'sd8388000, 24'sd255, 24'sd8388000, 24'sd0, 16'd0, 16'd0, 3'b100, 3'b100, 4'd15, 4'd15,
                 24'sd7864080, -24'sd240, 2'b01};
      vec[3] = '{24'sd0, 24'sd100, -24'sd8388608, 24'sd300, 16'hFFFF, 16'd0, 3'b111, 3'b010, 4'd8, 4'd4,
                 -24'sd4194304, 24'sd64, 2'b00};

      rst = 1'b1;
      bus.start = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      tick();
      check("reset_outputs", {bus.busy, bus.done, bus.sat, bus.audio}, 0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check("idle_after_reset", {bus.busy, bus.done, bus.sat, bus.audio}, 0);
         tick();
      end

      // sequence timing, with an ignored start while busy
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int cyc = 1; cyc <= 11; cyc++) begin
         check($sformatf("busy_cyc%0d", cyc), bus.busy, (cyc <= 8) ? 1 : 0);
         check($sformatf("done_cyc%0d", cyc), bus.done, (cyc == 9) ? 1 : 0);
         bus.start = (cyc == 3);
         tick();
      end
      bus.start = 1'b0;

      for (int i = 0; i < 4; i++) begin
         drive(vec[i].vi0, vec[i].vi1, vec[i].vd0, vec[i].vd1, 0, 0,
               vec[i].q0, vec[i].q1, vec[i].m0, vec[i].m1, vec[i].v0, vec[i].v1);
         run_seq();
         check($sformatf("vec%0d_audio0", i), $signed(bus.audio[23:0]), vec[i].a0);
         check($sformatf("vec%0d_audio1", i), $signed(bus.audio[47:24]), vec[i].a1);
         check($sformatf("vec%0d_sat", i), bus.sat, vec[i].sat);
         tick();
      end

      // ch1 saturates vhp, then a clean sequence clears the sticky bit
      drive(0, -24'sd8388608, 0, 0, 0, 0, 0, 0, 3'b100, 3'b100, 4'd15, 4'd15);
      run_seq();
      check("ch1_sat_set", bus.sat, 2'b10);
      check("ch1_sat_audio", $signed(bus.audio[47:24]), 7864080);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 3'b100, 3'b100, 4'd15, 4'd15);
      run_seq();
      check("ch1_sat_clear", bus.sat, 2'b00);
      check("ch1_clear_audio", $signed(bus.audio[47:24]), 0);
      tick();

      // reset in the middle of a sequence
      drive(vec[0].vi0, vec[0].vi1, vec[0].vd0, vec[0].vd1, 0, 0,
            vec[0].q0, vec[0].q1, vec[0].m0, vec[0].m1, vec[0].v0, vec[0].v1);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (4) tick();
      rst = 1'b1;
      #1;
      check("midrst_busy", bus.busy, 0);
      check("midrst_outputs", {bus.done, bus.sat, bus.audio}, 0);
      tick();
      rst = 1'b0;
      begin
         int dcount;
         dcount = 0;
         for (int i = 0; i < 12; i++) begin
            if (bus.done === 1'b1 || bus.busy === 1'b1) dcount++;
            tick();
         end
         check("midrst_no_done", dcount, 0);
      end
      run_seq();
      check("midrst_rerun_audio0", $signed(bus.audio[23:0]), vec[0].a0);
      check("midrst_rerun_audio1", $signed(bus.audio[47:24]), vec[0].a1);
      check("midrst_rerun_sat", bus.sat, vec[0].sat);
      tick();

      // random sequences against the reference model, state carried over
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_reset();
      for (int n = 0; n < 300; n++) begin
         logic signed [23:0] rvi0, rvi1, rvd0, rvd1;
         logic signed [15:0] rw0, rw1;
         rvi0 = $urandom(); rvi1 = $urandom();
         rvd0 = $urandom(); rvd1 = $urandom();
         rvi0 = rvi0 >>> $urandom_range(0, 12);
         rvi1 = rvi1 >>> $urandom_range(0, 12);
         rvd0 = rvd0 >>> $urandom_range(0, 12);
         rvd1 = rvd1 >>> $urandom_range(0, 12);
         rw0 = $urandom(); rw1 = $urandom();
         rw0 = rw0 >>> $urandom_range(0, 8);
         rw1 = rw1 >>> $urandom_range(0, 8);
         drive(rvi0, rvi1, rvd0, rvd1, rw0, rw1, 16'($urandom()), 16'($urandom()),
               3'($urandom()), 3'($urandom()), 4'($urandom()), 4'($urandom()));
         model_seq();
         run_seq();
         check($sformatf("rnd%0d_audio0", n), $signed(bus.audio[23:0]), exp_a[0]);
         check($sformatf("rnd%0d_audio1", n), $signed(bus.audio[47:24]), exp_a[1]);
         check($sformatf("rnd%0d_sat", n), bus.sat, {exp_s[1], exp_s[0]});
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
